// File: rtl/ixu_pkg.sv
// Shared types and constants for the IXU writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ixu_pkg;

  localparam int LANES_DEF = 4;  // bundle slots feeding writeback
  localparam int WB_PORTS  = 2;  // integer register-file write ports

  // One lane's EX/WB result.
  typedef struct packed {
    logic        nop;
    logic [4:0]  rd;
    logic [31:0] data;
  } lane_res_t;

  // One register-file write port.
  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_port_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    DRAIN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ixu_pick2.sv
// Finds the lowest and second-lowest set bits of a mask.
// Latency: combinational.
// Backpressure: none.
// Ports: mask (N bits) in; first_vld/first_idx and second_vld/second_idx out.
module ixu_pick2 #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic          first_vld,
  output logic [IW-1:0] first_idx,
  output logic          second_vld,
  output logic [IW-1:0] second_idx
);

  always_comb begin
    first_vld  = 1'b0;
    first_idx  = '0;
    second_vld = 1'b0;
    second_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        if (!first_vld) begin
          first_vld = 1'b1;
          first_idx = IW'(i);
        end else if (!second_vld) begin
          second_vld = 1'b1;
          second_idx = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ixu_wb_arb.sv
// Grants per-lane EX/WB results onto two integer write ports, stalling EX/WB to drain overflow.
// Latency: one cycle from a grant to the registered write-port outputs.
// Backpressure: stall_o (combinational) holds EX/WB while more than two results remain.
// Ports: lane_nop_i/lane_rd_i/lane_data_i per lane, flush_i; wp_en_o/wp_rd_o/wp_data_o,
//        waw_err_o, stall_o, stall_cnt_o (saturating count of stalled cycles).
module ixu_wb_arb
  import ixu_pkg::*;
#(
  parameter int LANES = LANES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES-1:0]      lane_nop_i,
  input  logic [LANES-1:0][4:0] lane_rd_i,
  input  logic [LANES-1:0][31:0] lane_data_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [1:0]            wp_en_o,
  output logic [1:0][4:0]       wp_rd_o,
  output logic [1:0][31:0]      wp_data_o,
  output logic                  waw_err_o,
  output logic [31:0]           stall_cnt_o
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  lane_res_t [LANES-1:0] lane;
  logic [LANES-1:0] elig, filt, p_mask, g_mask, r_mask;
  logic [LANES-1:0] pend_q, pend_d;
  arb_state_t state_q, state_d;
  logic waw_hit;
  logic v0, v1;
  logic [IW-1:0] i0, i1;
  wb_port_t [WB_PORTS-1:0] port_d, port_q;
  logic waw_q;
  logic [31:0] stall_cnt_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane[i] = '{nop: lane_nop_i[i], rd: lane_rd_i[i], data: lane_data_i[i]};
    end
  end

  // Eligible lanes, then drop any lane shadowed by a higher-index lane with the same rd.
  always_comb begin
    elig = '0;
    filt = '0;
    for (int i = 0; i < LANES; i++) begin
      elig[i] = !lane[i].nop && (lane[i].rd != 5'd0);
    end
    for (int i = 0; i < LANES; i++) begin
      filt[i] = elig[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (elig[j] && (lane[j].rd == lane[i].rd)) filt[i] = 1'b0;
      end
    end
  end

  assign waw_hit = |(elig & ~filt);
  assign p_mask  = (state_q == ACCEPT) ? filt : pend_q;

  ixu_pick2 #(.N(LANES), .IW(IW)) u_pick2 (
    .mask       (p_mask),
    .first_vld  (v0),
    .first_idx  (i0),
    .second_vld (v1),
    .second_idx (i1)
  );

  // Next-state, pending mask, stall and port grants.
  always_comb begin
    g_mask  = '0;
    state_d = ACCEPT;
    pend_d  = '0;
    port_d  = '0;
    if (v0) g_mask[i0] = 1'b1;
    if (v1) g_mask[i1] = 1'b1;
    r_mask  = p_mask & ~g_mask;
    // rst gating keeps stall low while reset holds state but live inputs are present.
    stall_o = (r_mask != '0) && !flush_i && !rst;
    if (!flush_i) begin
      if (r_mask != '0) begin
        state_d = DRAIN;
        pend_d  = r_mask;
      end
      if (v0) port_d[0] = '{en: 1'b1, rd: lane[i0].rd, data: lane[i0].data};
      if (v1) port_d[1] = '{en: 1'b1, rd: lane[i1].rd, data: lane[i1].data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCEPT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q      <= '0;
      waw_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      port_q <= port_d;
      waw_q  <= (state_q == ACCEPT) && waw_hit && !flush_i;
      if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < WB_PORTS; k++) begin
      wp_en_o[k]   = port_q[k].en;
      wp_rd_o[k]   = port_q[k].rd;
      wp_data_o[k] = port_q[k].data;
    end
  end

  assign waw_err_o   = waw_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ixu_wb_arb.sv
// Directed table-driven bench for ixu_wb_arb plus hand-written drain/flush/reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_ixu_wb_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       nop;
  logic [3:0][4:0]  rd;
  logic [3:0][31:0] data;
  logic             flush;
  logic             stall;
  logic [1:0]       wp_en;
  logic [1:0][4:0]  wp_rd;
  logic [1:0][31:0] wp_data;
  logic             waw;
  logic [31:0]      stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  ixu_wb_arb #(.LANES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .lane_nop_i  (nop),
    .lane_rd_i   (rd),
    .lane_data_i (data),
    .flush_i     (flush),
    .stall_o     (stall),
    .wp_en_o     (wp_en),
    .wp_rd_o     (wp_rd),
    .wp_data_o   (wp_data),
    .waw_err_o   (waw),
    .stall_cnt_o (stall_cnt)
  );

  typedef struct {
    logic [3:0]       nop;
    logic [3:0][4:0]  rd;
    logic [3:0][31:0] data;
    logic [1:0]       en;
    logic [4:0]       rd0;
    logic [31:0]      d0;
    logic [4:0]       rd1;
    logic [31:0]      d1;
    logic             waw;
  } vec_t;

  vec_t vec[9];

  function automatic vec_t mk(logic [3:0] n, logic [3:0][4:0] r, logic [3:0][31:0] d,
                              logic [1:0] en, logic [4:0] rd0, logic [31:0] d0,
                              logic [4:0] rd1, logic [31:0] d1, logic w);
    vec_t v;
    v.nop = n; v.rd = r; v.data = d; v.en = en;
    v.rd0 = rd0; v.d0 = d0; v.rd1 = rd1; v.d1 = d1; v.waw = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lanes 0..3 live with rd 1..4 and data 0x10..0x40.
  task automatic drive_four();
    nop  = 4'b0000;
    rd   = {5'd4, 5'd3, 5'd2, 5'd1};
    data = {32'h40, 32'h30, 32'h20, 32'h10};
  endtask

  task automatic drive_idle();
    nop  = 4'b1111;
    rd   = {5'd1, 5'd2, 5'd3, 5'd4};
    data = '0;
  endtask

  task automatic chk_ports(input string tag, input logic [1:0] en, input logic [4:0] r0,
                           input logic [31:0] d0, input logic [4:0] r1, input logic [31:0] d1);
    chk({tag, "_en"}, 64'(wp_en), 64'(en));
    chk({tag, "_rd0"}, 64'(wp_rd[0]), 64'(r0));
    chk({tag, "_d0"}, 64'(wp_data[0]), 64'(d0));
    chk({tag, "_rd1"}, 64'(wp_rd[1]), 64'(r1));
    chk({tag, "_d1"}, 64'(wp_data[1]), 64'(d1));
  endtask

  initial begin
    // Vector table: rd/data listed lane3..lane0.
    vec[0] = mk(4'b0101, {5'd7, 5'd3, 5'd5, 5'd2}, {32'h33, 32'hBEEF, 32'h11, 32'hDEAD},
                2'b11, 5'd5, 32'h11, 5'd7, 32'h33, 1'b0);
    vec[1] = mk(4'b1010, {5'd9, 5'd9, 5'd9, 5'd9}, {32'hDD, 32'hB, 32'hCC, 32'hA},
                2'b01, 5'd9, 32'hB, 5'd0, 32'h0, 1'b1);
    vec[2] = mk(4'b1010, {5'd8, 5'd4, 5'd6, 5'd0}, {32'h88, 32'h44, 32'h66, 32'h05},
                2'b01, 5'd4, 32'h44, 5'd0, 32'h0, 1'b0);
    vec[3] = mk(4'b1111, {5'd1, 5'd2, 5'd3, 5'd4}, {32'h1, 32'h2, 32'h3, 32'h4},
                2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
    vec[4] = mk(4'b0111, {5'd31, 5'd1, 5'd1, 5'd1}, {32'hFFFF_FFFF, 32'h1, 32'h2, 32'h3},
                2'b01, 5'd31, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0);
    vec[5] = mk(4'b0000, {5'd9, 5'd10, 5'd9, 5'd9}, {32'h3, 32'h4, 32'h2, 32'h1},
                2'b11, 5'd10, 32'h4, 5'd9, 32'h3, 1'b1);
    vec[6] = mk(4'b1110, {5'd12, 5'd12, 5'd12, 5'd12}, {32'h0, 32'h0, 32'hD, 32'hC},
                2'b01, 5'd12, 32'hC, 5'd0, 32'h0, 1'b0);
    vec[7] = mk(4'b0000, {5'd0, 5'd0, 5'd2, 5'd1}, {32'h400, 32'h300, 32'h200, 32'h100},
                2'b11, 5'd1, 32'h100, 5'd2, 32'h200, 1'b0);
    vec[8] = mk(4'b0000, {5'd0, 5'd20, 5'd20, 5'd0}, {32'h24, 32'h22, 32'h21, 32'h20},
                2'b01, 5'd20, 32'h22, 5'd0, 32'h0, 1'b1);

    // Initial reset.
    rst = 1'b1; flush = 1'b0;
    drive_idle();
    step(); step();
    chk("rst_stall", 64'(stall), 64'd0);
    chk_ports("rst", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("rst_waw", 64'(waw), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    step();

    // Single-cycle bundles, back to back.
    for (int i = 0; i < 9; i++) begin
      nop = vec[i].nop; rd = vec[i].rd; data = vec[i].data;
      #1;
      chk($sformatf("v%0d_stall", i), 64'(stall), 64'd0);
      step();
      chk_ports($sformatf("v%0d", i), vec[i].en, vec[i].rd0, vec[i].d0, vec[i].rd1, vec[i].d1);
      chk($sformatf("v%0d_waw", i), 64'(waw), 64'(vec[i].waw));
    end
    chk("tbl_cnt", 64'(stall_cnt), 64'(exp_cnt));

    // Four results: one stall cycle, lanes 0,1 then 2,3, then next bundle with no bubble.
    drive_four();
    #1;
    chk("four_stall0", 64'(stall), 64'd1);
    step(); exp_cnt++;
    chk_ports("four_a", 2'b11, 5'd1, 32'h10, 5'd2, 32'h20);
    chk("four_stall1", 64'(stall), 64'd0);
    chk("four_cnt", 64'(stall_cnt), 64'(exp_cnt));
    step();
    chk_ports("four_b", 2'b11, 5'd3, 32'h30, 5'd4, 32'h40);
    nop = vec[0].nop; rd = vec[0].rd; data = vec[0].data;
    #1;
    chk("next_stall", 64'(stall), 64'd0);
    step();
    chk_ports("next", 2'b11, 5'd5, 32'h11, 5'd7, 32'h33);
    chk("next_cnt", 64'(stall_cnt), 64'(exp_cnt));

    // Flush in ACCEPT on a 3-result bundle with a WAW conflict: nothing happens.
    nop  = 4'b0000;
    rd   = {5'd3, 5'd3, 5'd2, 5'd1};
    data = {32'h4, 32'h3, 32'h2, 32'h1};
    flush = 1'b1;
    #1;
    chk("flacc_stall", 64'(stall), 64'd0);
    step();
    flush = 1'b0;
    chk_ports("flacc", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("flacc_waw", 64'(waw), 64'd0);
    chk("flacc_cnt", 64'(stall_cnt), 64'(exp_cnt));
    drive_idle();
    step();

    // Flush in the DRAIN cycle: no second writes, back in ACCEPT afterwards.
    drive_four();
    #1;
    chk("fld_stall0", 64'(stall), 64'd1);
    step(); exp_cnt++;
    chk_ports("fld_a", 2'b11, 5'd1, 32'h10, 5'd2, 32'h20);
    flush = 1'b1;
    #1;
    chk("fld_stall1", 64'(stall), 64'd0);
    step();
    flush = 1'b0;
    chk_ports("fld_b", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("fld_cnt", 64'(stall_cnt), 64'(exp_cnt));
    // Same four results re-presented: ACCEPT sees all four and stalls once more.
    #1;
    chk("fld_accept", 64'(stall), 64'd1);
    step(); exp_cnt++;
    chk_ports("fld_c", 2'b11, 5'd1, 32'h10, 5'd2, 32'h20);
    step();
    chk_ports("fld_d", 2'b11, 5'd3, 32'h30, 5'd4, 32'h40);
    drive_idle();
    step();
    chk("fld_cnt2", 64'(stall_cnt), 64'(exp_cnt));

    // Reset in the DRAIN cycle with all lanes live: outputs clear at once.
    drive_four();
    #1;
    chk("rsd_stall0", 64'(stall), 64'd1);
    step();
    chk_ports("rsd_a", 2'b11, 5'd1, 32'h10, 5'd2, 32'h20);
    rst = 1'b1;
    #1;
    chk("rsd_stall", 64'(stall), 64'd0);
    chk_ports("rsd_b", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("rsd_waw", 64'(waw), 64'd0);
    chk("rsd_cnt", 64'(stall_cnt), 64'd0);
    drive_idle();
    #2;
    rst = 1'b0;
    step(); step();
    chk_ports("rsd_c", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("rsd_stall2", 64'(stall), 64'd0);
    chk("rsd_cnt2", 64'(stall_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ixu_wb_arb.md
# ixu_wb_arb

Writeback-port arbiter for the integer execution unit (IXU). Each cycle it takes the per-lane results held in the EX/WB pipeline registers of every VLIW bundle slot and grants them onto the register file's two integer write ports. When a bundle has more live results than ports, it asserts `stall_o` to freeze the EX/WB registers and drains the remaining results over following cycles. It also resolves same-destination (WAW) conflicts inside a bundle and keeps a stall-cycle performance counter.

## Interface
Parameters:
- `LANES`, default 4: bundle slots feeding writeback; legal range 2..8.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `lane_nop_i`, in, [LANES]: per-lane NOP flag from EX/WB.
- `lane_rd_i`, in, [LANES][5]: per-lane destination register.
- `lane_data_i`, in, [LANES][32]: per-lane result.
- `flush_i`, in, 1: discard the current bundle and any pending results.
- `stall_o`, out, 1: hold all EX/WB registers. Combinational.
- `wp_en_o`, out, [2]: write-port enables. Registered.
- `wp_rd_o`, out, [2][5]: write-port destinations. Registered.
- `wp_data_o`, out, [2][32]: write-port data. Registered.
- `waw_err_o`, out, 1: one-cycle pulse when a bundle has a WAW conflict. Registered.
- `stall_cnt_o`, out, 32: number of cycles `stall_o` has been high. Saturating.

## Operation
- **Eligible mask E.** A lane is in E when `!lane_nop_i` and `lane_rd_i != 0`. Writes to r0 and NOP lanes never consume a port.
- **WAW filter.** Lane i is removed from E if a higher-index eligible lane j has the same rd; the highest index wins. When any lane is removed this way, `waw_err_o` is 1 in the next cycle. This is evaluated only in ACCEPT.
- **State machine:**
  - ACCEPT: P = filtered E.
  - DRAIN: P = `pend` register.
  - Grant G = the lowest two set bits of P. Port 0 takes the lower lane index and port 1 the higher.
  - R = P & ~G. Then `stall_o` = (R != 0) & !`flush_i`.
  - If R != 0: next state is DRAIN and `pend` <= R.
  - Otherwise: next state is ACCEPT and `pend` <= 0.
- **Port outputs at each edge.** For each port k, `wp_en_o[k]` <= 1 if a grant exists for that port, otherwise 0. `wp_rd_o` and `wp_data_o` load the granted lane's values, or 0 when the port is not granted.
- **Input stability.** Inputs stay stable through DRAIN because `stall_o` holds EX/WB. The lane data used in DRAIN is therefore the live inputs.
- **Flush.** `flush_i` has the highest priority. It produces no grants, so `wp_en_o` <= 0. It also sets `pend` <= 0 and the next state to ACCEPT, forces `stall_o` to 0, and suppresses `waw_err_o`.
- **Stall counter.** `stall_cnt_o` increments on each cycle where `stall_o` = 1 and holds at 32'hFFFF_FFFF.
- **Reset values.** State ACCEPT, `pend` 0, all `wp_*` 0, `waw_err_o` 0, `stall_cnt_o` 0. `stall_o` is forced to 0 while `rst` is high.
- **Reset mid-DRAIN.** The remaining results are dropped and no further writes occur.

## Timing
- A result appears on a write port one cycle after the bundle is present at the EX/WB outputs. In DRAIN, this is one cycle after the granting cycle.
- A bundle with k eligible results, after the WAW filter, occupies max(1, ceil(k/2)) cycles. `stall_o` is high for ceil(k/2)-1 of those cycles.
- On the last drain cycle `stall_o` is 0. EX/WB loads the next bundle at that edge, and the block is in ACCEPT in the following cycle, so there is no bubble.
- With k = 0 or all NOPs, `wp_en_o` is 0 in the next cycle and no stall occurs.

## Structure
- Shared package `ixu_pkg` holds:
  - the `LANES` default;
  - the constant `WB_PORTS` = 2;
  - `typedef lane_res_t` {nop, rd[4:0], data[31:0]};
  - `typedef wb_port_t` {en, rd, data};
  - the state enum {ACCEPT, DRAIN}.
- Sub-module `ixu_pick2` is combinational. Given a LANES-wide mask, it returns the first and second lowest set-bit indices with their valid flags, and is reused for G.

## Test plan
- **Reset.** Assert `rst` mid-simulation with all lanes live. Required: every output is 0 immediately. After release with all lanes NOP, `wp_en_o` stays 00.
- **Two results, no stall.** Lanes 1 and 3 live with rd 5 and 7, data 0x11 and 0x33; lanes 0 and 2 NOP. Required: next cycle port0 = (5, 0x11), port1 = (7, 0x33), `stall_o` never high.
- **Four results, one stall.** Lanes 0..3 with rd 1..4. Required: `stall_o` is high for exactly 1 cycle. Writes are lanes 0,1 then lanes 2,3. `stall_cnt_o` = 1. The next bundle is accepted with no bubble.
- **WAW conflict.** Lanes 0 and 2 both rd 9, data 0xA and 0xB. Required: a single write rd9 = 0xB on port0, `waw_err_o` high for 1 cycle, no stall.
- **r0 and NOP filtering.** Lane0 rd 0, lane1 NOP, lane2 rd 4 data 0x44, lane3 NOP. Required: only port0 = (4, 0x44), `wp_en_o` = 01.
- **Flush and reset mid-DRAIN.** Present a 4-result bundle, then assert `flush_i` in the DRAIN cycle. Required: no second writes, `stall_o` drops in that cycle, and the state is ACCEPT. Repeat with `rst` in place of `flush_i`; the result is the same and `stall_cnt_o` = 0.
